// File: rtl/nlfsr_seq_gen.sv
// Fibonacci LFSR sequence generator with a runtime de Bruijn extension,
// parallel seed load, all-zero lock-up recovery and a period monitor.
module nlfsr_seq_gen #(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  TAPS  = 16'hD008,
   parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mode_db,
   output logic [WIDTH-1:0] o,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH:0]   period_last,
   output logic             lock_err
);

   localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   CNT_ONE   = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] start_reg;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH:0]   cnt;
   logic [WIDTH:0]   cnt_inc;
   logic [WIDTH:0]   period_reg;
   logic             wrap_reg;
   logic             lock_reg;
   logic             fb;
   logic             lock_hit;

   // De Bruijn mode inverts feedback whenever the low WIDTH-1 bits are zero,
   // splicing the all-zero state in between 100..0 and 00..1.
   always_comb begin
      fb = ^(state & TAPS);
      if (mode_db && (state[WIDTH-2:0] == '0)) begin
         fb = ~fb;
      end
      lock_hit   = !mode_db && (state == '0);
      next_state = lock_hit ? STATE_ONE : {state[WIDTH-2:0], fb};
      cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_ONE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= SEED;
         start_reg  <= SEED;
         cnt        <= '0;
         period_reg <= '0;
         wrap_reg   <= 1'b0;
         lock_reg   <= 1'b0;
      end else if (load) begin
         state     <= load_val;
         start_reg <= load_val;
         cnt       <= '0;
         wrap_reg  <= 1'b0;
         lock_reg  <= 1'b0;
      end else if (en) begin
         state    <= next_state;
         lock_reg <= lock_hit;
         if (next_state == start_reg) begin
            wrap_reg   <= 1'b1;
            period_reg <= cnt_inc;
            cnt        <= '0;
         end else begin
            wrap_reg <= 1'b0;
            cnt      <= cnt_inc;
         end
      end else begin
         wrap_reg <= 1'b0;
         lock_reg <= 1'b0;
      end
   end

   assign o           = state;
   assign bit_out     = state[WIDTH-1];
   assign wrap        = wrap_reg;
   assign period_last = period_reg;
   assign lock_err    = lock_reg;

endmodule

// File: tb/tb_nlfsr_seq_gen.sv
// Bench for nlfsr_seq_gen: three instances (16/4/8 bit) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_nlfsr_seq_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en0 = 1'b0, load0 = 1'b0, md0 = 1'b0;
   logic [15:0] lv0 = '0;
   logic [15:0] o0;
   logic [16:0] pl0;
   logic        b0, w0, le0;

   logic        en1 = 1'b0, load1 = 1'b0, md1 = 1'b0;
   logic [3:0]  lv1 = '0;
   logic [3:0]  o1;
   logic [4:0]  pl1;
   logic        b1, w1, le1;

   logic        en2 = 1'b0, load2 = 1'b0, md2 = 1'b0;
   logic [7:0]  lv2 = '0;
   logic [7:0]  o2;
   logic [8:0]  pl2;
   logic        b2, w2, le2;

   nlfsr_seq_gen u16 (
      .CLK(clk), .RST(rst), .en(en0), .load(load0), .load_val(lv0), .mode_db(md0),
      .o(o0), .bit_out(b0), .wrap(w0), .period_last(pl0), .lock_err(le0));

   nlfsr_seq_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u4 (
      .CLK(clk), .RST(rst), .en(en1), .load(load1), .load_val(lv1), .mode_db(md1),
      .o(o1), .bit_out(b1), .wrap(w1), .period_last(pl1), .lock_err(le1));

   nlfsr_seq_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) u8 (
      .CLK(clk), .RST(rst), .en(en2), .load(load2), .load_val(lv2), .mode_db(md2),
      .o(o2), .bit_out(b2), .wrap(w2), .period_last(pl2), .lock_err(le2));

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
         if (errors >= 200) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   endtask

   // Behavioural model: state as an integer, stepped with the generator rules.
   int unsigned     mw    [3] = '{16, 4, 8};
   longint unsigned mtaps [3] = '{64'hD008, 64'hC, 64'hB8};
   longint unsigned m_o [3], m_start [3], m_cnt [3], m_pl [3];
   bit              m_wrap [3], m_lock [3];

   task automatic model_step(input int k, input bit r, input bit ld,
                             input longint unsigned lv, input bit e, input bit md);
      longint unsigned mask, cmax, nxt;
      bit fb;
      mask = (64'd1 << mw[k]) - 64'd1;
      cmax = (64'd1 << (mw[k] + 1)) - 64'd1;
      if (r) begin
         m_o[k] = 1; m_start[k] = 1; m_cnt[k] = 0; m_pl[k] = 0;
         m_wrap[k] = 0; m_lock[k] = 0;
      end else if (ld) begin
         m_o[k] = lv & mask; m_start[k] = lv & mask; m_cnt[k] = 0;
         m_wrap[k] = 0; m_lock[k] = 0;
      end else if (e) begin
         if (!md && m_o[k] == 0) begin
            nxt = 1;
            m_lock[k] = 1;
         end else begin
            fb = ($countones(m_o[k] & mtaps[k]) % 2) == 1;
            if (md && ((m_o[k] & (mask >> 1)) == 0)) fb = !fb;
            nxt = ((m_o[k] << 1) & mask) | 64'(fb);
            m_lock[k] = 0;
         end
         if (nxt == m_start[k]) begin
            m_wrap[k] = 1;
            m_pl[k]   = (m_cnt[k] == cmax) ? cmax : m_cnt[k] + 1;
            m_cnt[k]  = 0;
         end else begin
            m_wrap[k] = 0;
            if (m_cnt[k] != cmax) m_cnt[k] = m_cnt[k] + 1;
         end
         m_o[k] = nxt;
      end else begin
         m_wrap[k] = 0;
         m_lock[k] = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst, load0, 64'(lv0), en0, md0);
      model_step(1, rst, load1, 64'(lv1), en1, md1);
      model_step(2, rst, load2, 64'(lv2), en2, md2);
   end

   task automatic check_inst(input int k, input longint unsigned o, input longint unsigned b,
                             input longint unsigned w, input longint unsigned pl,
                             input longint unsigned le);
      check($sformatf("o[%0d]", k), o, m_o[k]);
      check($sformatf("bit_out[%0d]", k), b, (m_o[k] >> (mw[k] - 1)) & 64'd1);
      check($sformatf("wrap[%0d]", k), w, 64'(m_wrap[k]));
      check($sformatf("period_last[%0d]", k), pl, m_pl[k]);
      check($sformatf("lock_err[%0d]", k), le, 64'(m_lock[k]));
   endtask

   always @(negedge clk) begin
      check_inst(0, 64'(o0), 64'(b0), 64'(w0), 64'(pl0), 64'(le0));
      check_inst(1, 64'(o1), 64'(b1), 64'(w1), 64'(pl1), 64'(le1));
      check_inst(2, 64'(o2), 64'(b2), 64'(w2), 64'(pl2), 64'(le2));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   bit          seen16 [65536];
   bit          seen8  [256];
   int unsigned n, dups, visited, wraps;
   bit          got, saw_zero;

   initial begin
      tick();
      rst = 1'b0;
      check("reset_o", 64'(o0), 64'h0001);
      check("reset_bit_out", 64'(b0), 0);
      check("reset_wrap", 64'(w0), 0);
      check("reset_period_last", 64'(pl0), 0);
      repeat (10) tick();
      check("hold_o", 64'(o0), 64'h0001);

      // Load 0x8000 then step in each mode.
      load0 = 1'b1; lv0 = 16'h8000; tick();
      load0 = 1'b0; en0 = 1'b1; tick();
      en0 = 1'b0;
      check("load_step_m0", 64'(o0), 64'h0001);
      load0 = 1'b1; lv0 = 16'h8000; md0 = 1'b1; tick();
      load0 = 1'b0; en0 = 1'b1; tick();
      check("db_insert_zero", 64'(o0), 64'h0000);
      tick();
      check("db_leave_zero", 64'(o0), 64'h0001);
      en0 = 1'b0; md0 = 1'b0;

      // Priority RST > load > en.
      rst = 1'b1; load0 = 1'b1; en0 = 1'b1; lv0 = 16'h1234; tick();
      check("prio_reset", 64'(o0), 64'h0001);
      rst = 1'b0; tick();
      check("prio_load", 64'(o0), 64'h1234);
      check("prio_load_wrap", 64'(w0), 0);
      load0 = 1'b0; en0 = 1'b0;

      // Full maximal period from reset with a visit bitmap.
      rst = 1'b1; tick(); rst = 1'b0;
      en0 = 1'b1; n = 0; got = 1'b0; dups = 0;
      while (!got && n < 70000) begin
         tick();
         n++;
         if (seen16[o0]) dups++;
         seen16[o0] = 1'b1;
         if (w0) got = 1'b1;
      end
      en0 = 1'b0;
      check("w16_wrap_seen", 64'(got), 1);
      check("w16_period_steps", 64'(n), 65535);
      check("w16_o_at_wrap", 64'(o0), 64'h0001);
      check("w16_period_last", 64'(pl0), 65535);
      visited = 0;
      for (int i = 0; i < 65536; i++) if (seen16[i]) visited++;
      check("w16_dups", 64'(dups), 0);
      check("w16_visited", 64'(visited), 65535);
      check("w16_zero_unvisited", 64'(seen16[0]), 0);

      // Zero load in mode 0: recovery on the next step, no wrap afterwards.
      load0 = 1'b1; lv0 = 16'h0000; tick();
      load0 = 1'b0; en0 = 1'b1; tick();
      check("lock_o", 64'(o0), 64'h0001);
      check("lock_err_pulse", 64'(le0), 1);
      check("lock_no_wrap", 64'(w0), 0);
      tick();
      check("lock_err_clear", 64'(le0), 0);
      wraps = 0;
      repeat (300) begin
         tick();
         if (w0) wraps++;
      end
      en0 = 1'b0;
      check("zero_start_no_wrap", 64'(wraps), 0);

      // 4-bit instance: 15 steps in mode 0, then 16 in de Bruijn mode.
      en1 = 1'b1; n = 0; got = 1'b0;
      while (!got && n < 100) begin
         tick(); n++;
         if (w1) got = 1'b1;
      end
      check("w4_m0_steps", 64'(n), 15);
      check("w4_m0_period_last", 64'(pl1), 15);
      check("w4_m0_o_at_wrap", 64'(o1), 1);
      md1 = 1'b1; n = 0; got = 1'b0; saw_zero = 1'b0;
      while (!got && n < 100) begin
         tick(); n++;
         if (o1 == 4'h0) saw_zero = 1'b1;
         if (w1) got = 1'b1;
      end
      en1 = 1'b0;
      check("w4_m1_steps", 64'(n), 16);
      check("w4_m1_period_last", 64'(pl1), 16);
      check("w4_m1_saw_zero", 64'(saw_zero), 1);

      // 8-bit instance in de Bruijn mode: every state exactly once.
      md2 = 1'b1; en2 = 1'b1; n = 0; got = 1'b0; dups = 0;
      while (!got && n < 1000) begin
         tick(); n++;
         if (seen8[o2]) dups++;
         seen8[o2] = 1'b1;
         if (w2) got = 1'b1;
      end
      en2 = 1'b0;
      visited = 0;
      for (int i = 0; i < 256; i++) if (seen8[i]) visited++;
      check("w8_db_steps", 64'(n), 256);
      check("w8_db_period_last", 64'(pl2), 256);
      check("w8_db_dups", 64'(dups), 0);
      check("w8_db_visited", 64'(visited), 256);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nlfsr_seq_gen.md
Name: nlfsr_seq_gen

Overview:
- Parametrised shift-register sequence generator: Fibonacci LFSR with a runtime-selectable de Bruijn extension.
  - Mode 0 (maximal LFSR): period 2^W-1, all-zero state excluded.
  - Mode 1 (de Bruijn): period 2^W, all-zero state inserted.
- Adds step enable, parallel seed load, lock-up recovery and a hardware period monitor.
- Serves as the scalable successor to the fixed 16-bit generator: pattern source for BIST, scrambler and stimulus paths.

Parameters:
- WIDTH, 16, state/output width; legal range 3..32.
- TAPS, 16'hD008, feedback tap mask (WIDTH bits); bit i set = state[i] feeds the XOR. Default is x^16+x^15+x^13+x^4+1.
- SEED, 1, reset state; must be nonzero.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- en  in  1  advance the state one step this cycle.
- load  in  1  load load_val into the state this cycle.
- load_val  in  WIDTH  load value.
- mode_db  in  1  0 = maximal LFSR, 1 = de Bruijn.
- o  out  WIDTH  current state.
- bit_out  out  1  o[WIDTH-1], the serial output.
- wrap  out  1  one-cycle pulse: state has returned to the start value.
- period_last  out  WIDTH+1  step count of the last completed period.
- lock_err  out  1  one-cycle pulse: recovery from all-zero state in mode 0.

Behaviour:
- Clock and reset: one clock (CLK); reset RST is synchronous and active-high. All outputs are registered.
- Reset values: o=SEED, start_reg=SEED, cnt=0, wrap=0, period_last=0, lock_err=0.
- Priority: RST > load > en. With none of them active, all state holds and the pulses return to 0.
- Step function, applied when en=1 and load=0:
  - fb = XOR over i of (state[i] & TAPS[i]).
  - If mode_db=1 and state[WIDTH-2:0]==0, then fb = ~fb.
  - next = {state[WIDTH-2:0], fb}.
- Lock recovery: mode_db=0 and state==0 at a step → next = 1, lock_err=1 for that one cycle. Otherwise lock_err=0.
- load:
  - state ← load_val, start_reg ← load_val, cnt ← 0, wrap ← 0.
  - Any value, including 0, is accepted. Recovery of a zero state happens at the next step, not at load.
- Period monitor, on each step:
  - If next == start_reg: wrap=1 (aligned with o showing the start value), period_last ← cnt+1, cnt ← 0.
  - Otherwise cnt ← cnt+1, saturating at all-ones, and wrap=0.
  - cnt is WIDTH+1 bits.
- Mode switching:
  - mode_db is sampled every step and takes effect on that step.
  - start_reg and cnt are not cleared on a mode change, so period_last after a mid-period switch is a mixed count.
- Non-recurring start value: if start_reg is 0 in mode 0, wrap never fires and cnt saturates. This is required behaviour, not an error.
- Reset mid-period: unconditional; period_last is cleared.
- Latency:
  - o reflects a step or load one cycle after the sampling edge.
  - wrap and lock_err coincide with the o value that caused them.

Test Plan:
- Reset, WIDTH=16 → o=0x0001, bit_out=0, wrap=0, period_last=0. Hold en=0 for 10 cycles → o stays 0x0001.
- Load 0x8000, then one step:
  - mode_db=0 → o=0x0001.
  - Reload 0x8000, mode_db=1, one step → o=0x0000; next step → o=0x0001.
- From reset, mode_db=0, en=1 continuously:
  - First wrap after exactly 65535 steps, with o=0x0001 at the pulse; period_last=65535.
  - Switch to mode_db=1 right after the wrap; next wrap after 65536 steps, period_last=65536.
  - Every 16-bit state is visited exactly once (scoreboard bitmap).
- Load 0x0000 with mode_db=0, one step → o=0x0001, lock_err high for exactly one cycle, wrap stays 0. Run 70000 steps → no wrap.
- Priority: RST=1, load=1, en=1 together → o=SEED. load=1 and en=1 together with load_val=0x1234 → o=0x1234, no step.
- Instance WIDTH=4, TAPS=4'hC, SEED=1: mode 0 wraps every 15 steps, mode 1 every 16 steps (period_last=15 and 16). Mode 1 sequence includes o=0.
